// File: rtl/bitlet_cs_resolver.sv
// -----------------------------------------------------------------------------
// bitlet_cs_resolver
//
// Purpose:
//   Accumulates a stream of carry-save beats (sum row + carry row) into a
//   two-row redundant accumulator using carry-save compression. No long carry
//   chain is needed while the group is accumulating. When the beat marked
//   in_last is accepted, the redundant accumulator is resolved to plain binary.
//   Resolution works CHUNK bits per cycle, from LSB to MSB, and a one-bit carry
//   passes between chunks. The result stays on out_data until the consumer
//   takes it.
//
// Parameters:
//   W      width of each incoming carry-save row
//   ACC_W  accumulator / result width (ACC_W >= W, multiple of CHUNK)
//   CHUNK  bits resolved per cycle; N = ACC_W / CHUNK resolve cycles
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   carry-save beat presented
//   in_ready   block accepts a beat this cycle (only while accumulating)
//   in_sum     sum row of the beat
//   in_carry   carry row of the beat (already bit-aligned)
//   in_last    beat closes the current accumulation group
//   out_valid  resolved result available
//   out_ready  consumer takes the result
//   out_data   resolved group sum, modulo 2^ACC_W
//   busy       high while resolving or holding a result
//
// Configuration macro:
//   BITLET_RESOLVER_SIGNED_EN  when defined, each incoming row is treated as
//                              two's complement and sign-extended to ACC_W.
//                              Otherwise rows are zero-extended.
// -----------------------------------------------------------------------------
module bitlet_cs_resolver #(
  parameter int W     = 16,
  parameter int ACC_W = 24,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  localparam int N     = ACC_W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Catch illegal parameter combinations at elaboration time.
  if (ACC_W < W) begin : g_bad_width
    $error("bitlet_cs_resolver: ACC_W must be >= W");
  end
  if ((ACC_W % CHUNK) != 0) begin : g_bad_chunk
    $error("bitlet_cs_resolver: ACC_W must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ACC_W-1:0] acc_s, acc_c;
  logic [ACC_W-1:0] ext_sum, ext_carry;
  logic [ACC_W-1:0] l1_s, l1_c, l2_s, l2_c;

  logic [IDX_W-1:0] idx;
  logic             chunk_cy;
  logic [CHUNK-1:0] s_chunk, c_chunk, r_chunk;
  logic             r_cy;

  logic accept;
  logic take_out;

  // Widen incoming rows to the accumulator width. A size cast of a signed
  // expression sign-extends. A size cast of an unsigned one zero-extends.
`ifdef BITLET_RESOLVER_SIGNED_EN
  assign ext_sum   = ACC_W'($signed(in_sum));
  assign ext_carry = ACC_W'($signed(in_carry));
`else
  assign ext_sum   = ACC_W'(in_sum);
  assign ext_carry = ACC_W'(in_carry);
`endif

  // The 4:2 compressor is two stacked 3:2 carry-save layers. Each layer only
  // moves a carry one bit left. The bit shifted out at the top is dropped,
  // which gives the mod 2^ACC_W wrap.
  always_comb begin
    l1_s = acc_s ^ acc_c ^ ext_sum;
    l1_c = ((acc_s & acc_c) | (acc_s & ext_sum) | (acc_c & ext_sum)) << 1;
    l2_s = l1_s ^ l1_c ^ ext_carry;
    l2_c = ((l1_s & l1_c) | (l1_s & ext_carry) | (l1_c & ext_carry)) << 1;
  end

  // Chunk adder for resolution. It picks the current chunk of each row and
  // adds it with the carry left over from the previous chunk.
  always_comb begin
    s_chunk = CHUNK'(acc_s >> (idx * CHUNK));
    c_chunk = CHUNK'(acc_c >> (idx * CHUNK));
    {r_cy, r_chunk} = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, chunk_cy};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. The handshakes depend on state only, so
  // there is no combinational path from input to output.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && in_last) begin
          state_next = RESOLVE;
        end
      end
      RESOLVE: begin
        if (idx == LAST_IDX) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign take_out = out_valid && out_ready;

  // Datapath. The accumulator is updated on every accepted beat. The resolve
  // index and carry are re-armed when the closing beat arrives. Each resolve
  // cycle writes one chunk of out_data. The carry out of the top chunk is
  // written to chunk_cy but never used, because the next group re-arms it.
  // The accumulator clears when the result is handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s    <= '0;
      acc_c    <= '0;
      out_data <= '0;
      idx      <= '0;
      chunk_cy <= 1'b0;
    end else begin
      if (accept) begin
        acc_s <= l2_s;
        acc_c <= l2_c;
        if (in_last) begin
          idx      <= '0;
          chunk_cy <= 1'b0;
        end
      end

      if (state == RESOLVE) begin
        for (int k = 0; k < N; k++) begin
          if (idx == IDX_W'(k)) begin
            out_data[k*CHUNK +: CHUNK] <= r_chunk;
          end
        end
        chunk_cy <= r_cy;
        idx      <= idx + 1'b1;
      end

      if (take_out) begin
        acc_s <= '0;
        acc_c <= '0;
      end
    end
  end

endmodule

// File: doc/bitlet_cs_resolver.md
BITLET_CS_RESOLVER -- requirements
Module: bitlet_cs_resolver

Interface
REQ-001 SHALL have parameter W, default 16: width of each incoming carry-save row.
REQ-002 SHALL have parameter ACC_W, default 24: accumulator and result width; ACC_W >= W.
REQ-003 SHALL have parameter CHUNK, default 8: bits resolved per cycle; ACC_W is an integer multiple of CHUNK; N = ACC_W/CHUNK.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  a carry-save beat is presented.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_sum  input  W  sum row of a beat.
REQ-009 SHALL have port in_carry  input  W  carry row of a beat (already bit-aligned).
REQ-010 SHALL have port in_last  input  1  beat closes the current accumulation group.
REQ-011 SHALL have port out_valid  output  1  resolved binary result available.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_data  output  ACC_W  resolved binary sum of the group, modulo 2^ACC_W.
REQ-014 SHALL have port busy  output  1  high in RESOLVE or OUTPUT.

Function
REQ-015 SHALL implement states ACCUM, RESOLVE, OUTPUT; busy = (state != ACCUM).
REQ-016 SHALL drive in_ready = 1 only in ACCUM; out_valid = 1 only in OUTPUT.
REQ-017 SHALL, on an accepting edge (in_valid && in_ready), compress {acc_s, acc_c, ext(in_sum), ext(in_carry)} into new two-row acc_s/acc_c via 4-input-to-2-row carry-save compression, mod 2^ACC_W, with no carry propagation across more than one bit position.
REQ-018 SHALL, when the accepted beat has in_last = 1, move ACCUM -> RESOLVE on that same edge, with resolve chunk index = 0 and chunk carry = 0.
REQ-019 SHALL, on each RESOLVE edge, add bits [i*CHUNK +: CHUNK] of acc_s and acc_c plus chunk carry, write the CHUNK-bit result into out_data at the same position, store the carry-out, and increment i.
REQ-020 SHALL move RESOLVE -> OUTPUT on the edge that resolves chunk N-1; the final carry-out is discarded (wrap-around).
REQ-021 SHALL assert out_valid exactly N rising edges after the edge that accepted in_last; with default parameters this is 3 edges.
REQ-022 SHALL hold out_valid and out_data stable in OUTPUT until out_ready = 1.
REQ-023 SHALL, on an edge with out_valid && out_ready, clear acc_s and acc_c to 0 and move OUTPUT -> ACCUM; in_ready rises after that edge (no same-cycle bypass).
REQ-024 SHALL ignore in_valid, in_sum, in_carry and in_last outside ACCUM.
REQ-025 SHALL leave out_data unchanged while in ACCUM; out_data is only meaningful while out_valid = 1.
REQ-026 SHALL accept a group of one beat (in_last on the first beat) and groups of unbounded length; accumulation wraps mod 2^ACC_W.

Reset
REQ-027 SHALL, while rst_n = 0, force state = ACCUM, acc_s = acc_c = 0, out_data = 0, chunk index = 0, and chunk carry = 0; this gives in_ready = 1, out_valid = 0 and busy = 0.
REQ-028 SHALL, when reset asserts mid-RESOLVE or mid-OUTPUT, discard the group with no partial result.

Configuration
REQ-029 SHALL support macro BITLET_RESOLVER_SIGNED_EN.
REQ-030 SHALL, with BITLET_RESOLVER_SIGNED_EN defined, set ext() to sign-extend each W-bit row from bit W-1 to ACC_W, treating each row as two's complement.
REQ-031 SHALL, without BITLET_RESOLVER_SIGNED_EN, set ext() to zero-extend each row to ACC_W; all other behaviour is identical.

Verification (W=16, ACC_W=24, CHUNK=8)
REQ-032 SHALL cover: rst_n low during RESOLVE -> in_ready=1, out_valid=0, busy=0 immediately; the next group's result excludes prior beats.
REQ-033 SHALL cover: one beat sum=0x1234, carry=0x0010, last=1, out_ready=1 -> out_data=0x001244 with out_valid high 3 edges after acceptance, for 1 cycle.
REQ-034 SHALL cover: 3 back-to-back beats sum=0xFFFF, carry=0x0001, last on the third -> out_data=0x030000.
REQ-035 SHALL cover: 256 beats sum=0xFFFF, carry=0xFFFF -> out_data=0xFFFE00 (wrap of 0x1FFFE00).
REQ-036 SHALL cover: out_ready low for 5 cycles in OUTPUT -> out_data stable, in_ready=0; after handshake the next single beat 0x0001/0x0000 yields 0x000001.
REQ-037 SHALL cover: sum=0xFFFF, carry=0xFFFE, last -> out_data=0xFFFFFD with BITLET_RESOLVER_SIGNED_EN, 0x01FFFD without.
